// File: rtl/ext_bus_pkg.sv
// Shared OBI bus types, address-map rule type and decode helpers for the
// external peripheral crossbar ext_obi_xbar_rr.
package ext_bus_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  typedef struct packed {
    logic       req;
    addr_t      addr;
    logic       we;
    logic [3:0] be;
    data_t      wdata;
  } obi_req_t;

  typedef struct packed {
    logic  gnt;
    logic  rvalid;
    data_t rdata;
  } obi_resp_t;

  typedef struct packed {
    logic [31:0] idx;
    addr_t       start_addr;
    addr_t       end_addr;
  } rule_t;

  localparam data_t ERR_RDATA = 32'hBADACCE5;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Half-open window: start inclusive, end exclusive.
  function automatic logic rule_match(input rule_t r, input addr_t a);
    return (a >= r.start_addr) && (a < r.end_addr);
  endfunction

endpackage

// File: rtl/ext_obi_rr_arbiter.sv
// Round-robin picker for one crossbar slave port; the pointer moves past the
// winner only when the slave actually grants.
module ext_obi_rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     i_req,
  input  logic             i_adv,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_hi_valid, w_lo_valid;
  logic [IDX_W-1:0] w_hi_idx, w_lo_idx;

  // First requester at or above the pointer, else the first one from zero.
  always_comb begin
    w_hi_valid = 1'b0;
    w_lo_valid = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_req[i] && !w_lo_valid) begin
        w_lo_valid = 1'b1;
        w_lo_idx   = IDX_W'(i);
      end
      if (i_req[i] && !w_hi_valid && (IDX_W'(i) >= r_ptr)) begin
        w_hi_valid = 1'b1;
        w_hi_idx   = IDX_W'(i);
      end
    end
  end

  assign o_valid = w_lo_valid;
  assign o_idx   = w_hi_valid ? w_hi_idx : w_lo_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (o_idx == IDX_W'(N - 1)) ? '0 : o_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/ext_obi_xbar_rr.sv
// N-master x M-slave OBI crossbar with per-slave round-robin, outstanding
// tracking and in-order response routing. Macro EXT_BUS_DECODE_ERR_EN adds an error slave.
module ext_obi_xbar_rr
  import ext_bus_pkg::*;
#(
  parameter  int unsigned NMASTER    = 7,
  parameter  int unsigned NSLAVE     = 2,
  parameter  int unsigned NUM_RULES  = 2,
  parameter  int unsigned MAX_OUTST  = 4,
  parameter  int unsigned SLV_FIFO_D = 4,
  localparam int unsigned MIDX_W     = idx_width(NMASTER),
  localparam int unsigned SIDX_W     = idx_width(NSLAVE)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  rule_t     [NUM_RULES-1:0]  addr_map_i,
  input  logic      [SIDX_W-1:0]     default_idx_i,
  input  obi_req_t  [NMASTER-1:0]    master_req_i,
  output obi_resp_t [NMASTER-1:0]    master_resp_o,
  output obi_req_t  [NSLAVE-1:0]     slave_req_o,
  input  obi_resp_t [NSLAVE-1:0]     slave_resp_i
);

`ifdef EXT_BUS_DECODE_ERR_EN
  localparam int unsigned NTGT = NSLAVE + 1;
`else
  localparam int unsigned NTGT = NSLAVE;
`endif
  localparam int unsigned TGT_W  = idx_width(NTGT);
  localparam int unsigned CNT_W  = idx_width(MAX_OUTST + 1);
  localparam int unsigned PTR_W  = idx_width(SLV_FIFO_D);
  localparam int unsigned FCNT_W = idx_width(SLV_FIFO_D + 1);

  logic [NMASTER-1:0][TGT_W-1:0] w_dec;
  logic [NMASTER-1:0]            w_elig;
  logic [NTGT-1:0][MIDX_W-1:0]   w_win, w_head;
  logic [NTGT-1:0][31:0]         w_tgt_rdata;
  logic [NTGT-1:0]               w_arb_valid, w_fwd, w_tgt_gnt, w_tgt_rvalid;
  logic [NTGT-1:0]               w_pop, w_empty, w_full;

  for (genvar m = 0; m < NMASTER; m++) begin : g_mst
    logic             w_hit, w_gnt, w_rvalid;
    logic [TGT_W-1:0] w_rule_tgt, r_cur;
    logic [CNT_W-1:0] r_cnt, w_eff_cnt;
    logic [31:0]      w_rdata;

    always_comb begin
      w_hit      = 1'b0;
      w_rule_tgt = '0;
      for (int unsigned r = 0; r < NUM_RULES; r++) begin
        if (!w_hit && (addr_map_i[r].idx < NSLAVE) &&
            rule_match(addr_map_i[r], master_req_i[m].addr)) begin
          w_hit      = 1'b1;
          w_rule_tgt = TGT_W'(addr_map_i[r].idx);
        end
      end
    end

`ifdef EXT_BUS_DECODE_ERR_EN
    assign w_dec[m] = w_hit ? w_rule_tgt : TGT_W'(NSLAVE);
`else
    assign w_dec[m] = w_hit ? w_rule_tgt : default_idx_i;
`endif

    // A response retiring this cycle already frees its slot, so a saturated
    // master can be re-granted in the same cycle.
    assign w_eff_cnt = r_cnt - CNT_W'(w_rvalid);
    assign w_elig[m] = master_req_i[m].req && (w_eff_cnt < CNT_W'(MAX_OUTST)) &&
                       ((w_eff_cnt == '0) || (w_dec[m] == r_cur));

    always_comb begin
      w_gnt    = 1'b0;
      w_rvalid = 1'b0;
      w_rdata  = '0;
      for (int unsigned t = 0; t < NTGT; t++) begin
        if (w_tgt_gnt[t] && (w_win[t] == MIDX_W'(m))) w_gnt = 1'b1;
        if (w_pop[t] && (w_head[t] == MIDX_W'(m))) begin
          w_rvalid = 1'b1;
          w_rdata  = w_tgt_rdata[t];
        end
      end
    end

    assign master_resp_o[m] = '{gnt: w_gnt, rvalid: w_rvalid, rdata: w_rdata};

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt <= '0;
        r_cur <= '0;
      end else begin
        if (w_gnt && !w_rvalid)      r_cnt <= r_cnt + CNT_W'(1);
        else if (!w_gnt && w_rvalid) r_cnt <= r_cnt - CNT_W'(1);
        if (w_gnt) r_cur <= w_dec[m];
      end
    end
  end

  for (genvar t = 0; t < NTGT; t++) begin : g_tgt
    logic [NMASTER-1:0] w_req;
    logic [MIDX_W-1:0]  r_mem [SLV_FIFO_D];
    logic [PTR_W-1:0]   r_wptr, r_rptr;
    logic [FCNT_W-1:0]  r_fcnt;

    always_comb begin
      w_req = '0;
      for (int unsigned m = 0; m < NMASTER; m++) begin
        w_req[m] = w_elig[m] && (w_dec[m] == TGT_W'(t));
      end
    end

    ext_obi_rr_arbiter #(
      .N     (NMASTER),
      .IDX_W (MIDX_W)
    ) u_arb (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_req   (w_req),
      .i_adv   (w_tgt_gnt[t]),
      .o_valid (w_arb_valid[t]),
      .o_idx   (w_win[t])
    );

    assign w_empty[t] = (r_fcnt == '0);
    assign w_full[t]  = (r_fcnt == FCNT_W'(SLV_FIFO_D));
    assign w_pop[t]   = w_tgt_rvalid[t] && !w_empty[t];
    // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
    assign w_fwd[t]   = w_arb_valid[t] && (!w_full[t] || w_pop[t]);
    assign w_head[t]  = r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
      if (w_tgt_gnt[t]) r_mem[r_wptr] <= w_win[t];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_fcnt <= '0;
      end else begin
        if (w_tgt_gnt[t]) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop[t])     r_rptr <= r_rptr + PTR_W'(1);
        if (w_tgt_gnt[t] && !w_pop[t])      r_fcnt <= r_fcnt + FCNT_W'(1);
        else if (!w_tgt_gnt[t] && w_pop[t]) r_fcnt <= r_fcnt - FCNT_W'(1);
      end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
      if (rst_ni) assert (!(w_tgt_rvalid[t] && w_empty[t]));
    end
`endif

    if (t < NSLAVE) begin : g_slv
      assign slave_req_o[t]  = w_fwd[t] ? master_req_i[w_win[t]] : '0;
      assign w_tgt_gnt[t]    = w_fwd[t] && slave_resp_i[t].gnt;
      assign w_tgt_rvalid[t] = slave_resp_i[t].rvalid;
      assign w_tgt_rdata[t]  = slave_resp_i[t].rdata;
    end else begin : g_err
      logic r_err_rvalid;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_err_rvalid <= 1'b0;
        else         r_err_rvalid <= w_fwd[t];
      end
      assign w_tgt_gnt[t]    = w_fwd[t];
      assign w_tgt_rvalid[t] = r_err_rvalid;
      assign w_tgt_rdata[t]  = ERR_RDATA;
    end
  end

endmodule
